data_ram_slave: RTL and testbench

DATA_RAM_SLAVE -- requirements
Module: data_ram_slave

---
 rtl/data_ram_pkg.sv | 20 ++
 rtl/if_ram_2way_32b_data.sv | 24 ++
 rtl/data_ram_array.sv | 61 ++++++
 rtl/data_ram_slave.sv | 73 +++++++
 tb/tb_data_ram_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants, word type and lane-parity helper for the data RAM slave.
package data_ram_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * LANE_W;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [WORD_BYTES-1:0] lanes_t;

    // Even parity per byte lane: the stored bit makes the lane's total ones count even.
    function automatic lanes_t lane_parity(input word_t w);
        lanes_t p;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            p[i] = ^w[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/if_ram_2way_32b_data.sv
// 32-bit data RAM interface: master drives the access every cycle, slave answers one cycle later.
interface if_ram_2way_32b_data #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import data_ram_pkg::*;

    logic                  ram_we;
    lanes_t                ram_be;
    logic [ADDR_WIDTH-1:0] ram_addr;
    word_t                 ram_wdata;
    word_t                 ram_rdata;
    logic                  ram_err;

    modport MASTER (
        output ram_we, ram_be, ram_addr, ram_wdata,
        input  ram_rdata, ram_err
    );

    modport SLAVE (
        input  ram_we, ram_be, ram_addr, ram_wdata,
        output ram_rdata, ram_err
    );

endinterface

// File: rtl/data_ram_array.sv
// Byte-write word array with registered write-first read.
// Optional per-lane even parity storage and check when DATA_RAM_PARITY_EN is defined.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  lanes_t                         be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  word_t                          wdata,
    output word_t                          rdata,
    output logic                           par_err_c
);

    word_t mem [DEPTH_WORDS];

    // Each lane returns the freshly written byte when written, otherwise the stored byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (we && be[i]) begin
                mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                rdata[i*LANE_W +: LANE_W]    <= wdata[i*LANE_W +: LANE_W];
            end else begin
                rdata[i*LANE_W +: LANE_W]    <= mem[idx][i*LANE_W +: LANE_W];
            end
        end
    end

`ifdef DATA_RAM_PARITY_EN
    lanes_t par_mem [DEPTH_WORDS];
    lanes_t wpar;
    lanes_t rpar;

    always_comb begin
        wpar = lane_parity(wdata);
    end

    // Parity travels with its lane so a partial write keeps untouched lanes' parity intact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (we && be[i]) begin
                par_mem[idx][i] <= wpar[i];
                rpar[i]         <= wpar[i];
            end else begin
                rpar[i]         <= par_mem[idx][i];
            end
        end
    end

    always_comb begin
        par_err_c = |(lane_parity(rdata) ^ rpar);
    end
`else
    always_comb begin
        par_err_c = 1'b0;
    end
`endif

endmodule

// File: rtl/data_ram_slave.sv
// Data RAM slave: address decode, error flagging and output muxing around data_ram_array.
// Define DATA_RAM_PARITY_EN to add per-lane parity storage and read checking.
module data_ram_slave
    import data_ram_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH  = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter longint unsigned BASE_ADDR   = 0
) (
    input logic                    clk_i,
    input logic                    rst_i,
    if_ram_2way_32b_data.SLAVE     ram_if
);

    localparam int unsigned AW1   = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [AW1-1:0]        addr_ext;
    logic [AW1-1:0]        base_ext;
    logic [AW1-1:0]        limit_ext;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  acc_err;
    logic                  wr_en;

    logic                  err_q;
    logic                  valid_q;
    word_t                 arr_rdata;
    logic                  par_err_c;

    // Decode in one extra bit so a window ending at the top of the address space cannot wrap.
    always_comb begin
        addr_ext   = {1'b0, ram_if.ram_addr};
        base_ext   = AW1'(BASE_ADDR);
        limit_ext  = base_ext + AW1'(64'(DEPTH_WORDS) * 64'(WORD_BYTES));
        in_range   = (addr_ext >= base_ext) && (addr_ext < limit_ext);
        misaligned = (ram_if.ram_addr[1:0] != 2'b00);
        acc_err    = !in_range || misaligned;
        offset     = ram_if.ram_addr - ADDR_WIDTH'(BASE_ADDR);
        idx        = IDX_W'(offset >> 2);
        wr_en      = !rst_i && !acc_err && ram_if.ram_we;
    end

    data_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk       (clk_i),
        .we        (wr_en),
        .be        (ram_if.ram_be),
        .idx       (idx),
        .wdata     (ram_if.ram_wdata),
        .rdata     (arr_rdata),
        .par_err_c (par_err_c)
    );

    // Per-cycle status: error for a bad address, valid for a serviced access, neither during reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            err_q   <= acc_err;
            valid_q <= !acc_err;
        end
    end

    // Parity errors still return the raw word; address errors and reset return zero.
    assign ram_if.ram_rdata = valid_q ? arr_rdata : '0;
    assign ram_if.ram_err   = err_q || (valid_q && par_err_c);

endmodule

// File: tb/tb_data_ram_slave.sv
// Directed self-checking bench for data_ram_slave (both builds; parity scenario under DATA_RAM_PARITY_EN).
module tb_data_ram_slave;
    import data_ram_pkg::*;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DEPTH_WORDS = 1024;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    if_ram_2way_32b_data #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    data_ram_slave #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ram_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one access for one clock; returns 1 time unit after the edge, when its response is visible.
    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr, input word_t wdata);
        bus.ram_we    = we;
        bus.ram_be    = be;
        bus.ram_addr  = addr;
        bus.ram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            access(1'b0, 4'hF, 32'h0, 32'h0);
            checks++;
            if (bus.ram_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata: got %h expected %h", bus.ram_rdata, 32'h0);
            end
            checks++;
            if (bus.ram_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_err: got %b expected %b", bus.ram_err, 1'b0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        checks++;
        if (bus.ram_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_first: got %h expected %h", bus.ram_rdata, 32'hDEADBEEF);
        end
        access(1'b0, 4'h0, 32'h10, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_10: got %h expected %h", bus.ram_rdata, 32'hDEADBEEF);
        end
        checks++;
        if (bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL read_10_err: got %b expected %b", bus.ram_err, 1'b0);
        end
    endtask

    task automatic test_byte_lanes();
        access(1'b1, 4'b0001, 32'h10, 32'h000000AA);
        checks++;
        if (bus.ram_rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL lane0_write_first: got %h expected %h", bus.ram_rdata, 32'hDEADBEAA);
        end
        access(1'b0, 4'b0000, 32'h10, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL lane0_read: got %h expected %h", bus.ram_rdata, 32'hDEADBEAA);
        end
        access(1'b1, 4'b0000, 32'h10, 32'h99999999);
        checks++;
        if (bus.ram_rdata !== 32'hDEADBEAA || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_write: got %h err %b expected %h err 0", bus.ram_rdata, bus.ram_err, 32'hDEADBEAA);
        end
        access(1'b1, 4'b0100, 32'h10, 32'h00CC0000);
        access(1'b0, 4'b0001, 32'h10, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hDECCBEAA) begin
            errors++;
            $display("FAIL lane2_read: got %h expected %h", bus.ram_rdata, 32'hDECCBEAA);
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 4'hF, 32'h20, 32'h12345678);
        checks++;
        if (bus.ram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_n1: got %h expected %h", bus.ram_rdata, 32'h12345678);
        end
        access(1'b0, 4'hF, 32'h20, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_n2: got %h expected %h", bus.ram_rdata, 32'h12345678);
        end
    endtask

    task automatic test_range();
        access(1'b1, 4'hF, 32'h0,   32'h11111111);
        access(1'b1, 4'hF, 32'hFFC, 32'h22222222);
        access(1'b1, 4'hF, 32'h1000, 32'hBADBAD00);
        checks++;
        if (bus.ram_err !== 1'b1 || bus.ram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_write: got err %b rdata %h expected err 1 rdata 0", bus.ram_err, bus.ram_rdata);
        end
        access(1'b0, 4'hF, 32'h0, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'h11111111 || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_read_0: got %h err %b expected %h err 0", bus.ram_rdata, bus.ram_err, 32'h11111111);
        end
        access(1'b0, 4'hF, 32'hFFC, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'h22222222 || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_read_ffc: got %h err %b expected %h err 0", bus.ram_rdata, bus.ram_err, 32'h22222222);
        end
        access(1'b0, 4'hF, 32'hFFFFFFFC, 32'h0);
        checks++;
        if (bus.ram_err !== 1'b1 || bus.ram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL top_addr: got err %b rdata %h expected err 1 rdata 0", bus.ram_err, bus.ram_rdata);
        end
    endtask

    task automatic test_misaligned();
        access(1'b0, 4'hF, 32'h12, 32'h0);
        checks++;
        if (bus.ram_err !== 1'b1 || bus.ram_rdata !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_read: got err %b rdata %h expected err 1 rdata 0", bus.ram_err, bus.ram_rdata);
        end
        access(1'b1, 4'hF, 32'h11, 32'h77777777);
        checks++;
        if (bus.ram_err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_write_b2b: got err %b expected 1", bus.ram_err);
        end
        access(1'b0, 4'hF, 32'h10, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hDECCBEAA || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_suppress: got %h err %b expected %h err 0", bus.ram_rdata, bus.ram_err, 32'hDECCBEAA);
        end
    endtask

    task automatic test_reset_write();
        access(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        rst = 1'b1;
        access(1'b1, 4'hF, 32'h30, 32'h00000055);
        checks++;
        if (bus.ram_rdata !== 32'h0 || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_out: got %h err %b expected 0 err 0", bus.ram_rdata, bus.ram_err);
        end
        rst = 1'b0;
        access(1'b0, 4'hF, 32'h30, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hCAFEF00D || bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_kept: got %h err %b expected %h err 0", bus.ram_rdata, bus.ram_err, 32'hCAFEF00D);
        end
        access(1'b0, 4'hF, 32'h10, 32'h0);
        checks++;
        if (bus.ram_rdata !== 32'hDECCBEAA) begin
            errors++;
            $display("FAIL reset_persist: got %h expected %h", bus.ram_rdata, 32'hDECCBEAA);
        end
    endtask

`ifdef DATA_RAM_PARITY_EN
    task automatic test_parity();
        access(1'b1, 4'hF, 32'h40, 32'h0F0F0F0F);
        checks++;
        if (bus.ram_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean: got err %b expected 0", bus.ram_err);
        end
        dut.u_array.par_mem[16][0] = ~dut.u_array.par_mem[16][0];
        access(1'b0, 4'hF, 32'h40, 32'h0);
        checks++;
        if (bus.ram_err !== 1'b1 || bus.ram_rdata !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL parity_flip: got err %b rdata %h expected err 1 rdata %h", bus.ram_err, bus.ram_rdata, 32'h0F0F0F0F);
        end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.ram_we    = 1'b0;
        bus.ram_be    = 4'h0;
        bus.ram_addr  = 32'h0;
        bus.ram_wdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_range();
        test_misaligned();
        test_reset_write();
`ifdef DATA_RAM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
